instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 36 +++
 rtl/instr_fetch_unit_if.sv | 24 ++
 rtl/instr_fetch_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared processor definitions: opcode values, instruction layout and the
// fetch-unit state encoding.
package instr_fetch_unit_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned OPC_W  = 8;

    localparam logic [OPC_W-1:0] OPC_CLAC  = 8'd1;
    localparam logic [OPC_W-1:0] OPC_MVAC  = 8'd2;
    localparam logic [OPC_W-1:0] OPC_COPY  = 8'd3;
    localparam logic [OPC_W-1:0] OPC_ADD   = 8'd4;
    localparam logic [OPC_W-1:0] OPC_LOAD  = 8'd5;
    localparam logic [OPC_W-1:0] OPC_SUB   = 8'd6;
    localparam logic [OPC_W-1:0] OPC_MUL   = 8'd7;
    localparam logic [OPC_W-1:0] OPC_INDAC = 8'd8;
    localparam logic [OPC_W-1:0] OPC_STOR  = 8'd9;
    localparam logic [OPC_W-1:0] OPC_LODM  = 8'd10;
    localparam logic [OPC_W-1:0] OPC_JPNZ  = 8'd16;
    localparam logic [OPC_W-1:0] OPC_END   = 8'd30;

    typedef struct packed {
        logic [OPC_W-1:0] rsel;
        logic [OPC_W-1:0] opcode;
    } instr_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH1,
        LATCH1,
        FETCH2,
        LATCH2,
        ISSUE,
        HALT
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port plus the instruction handshake towards the core.
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic              im_read;
    logic [WORD_W-1:0] im_address;
    logic [WORD_W-1:0] im_data;
    instr_t            instr_out;
    logic [WORD_W-1:0] operand_out;
    logic              instr_valid;
    logic              instr_ready;
    logic              acc_nz;

    modport master (
        output im_read, im_address, instr_out, operand_out, instr_valid,
        input  im_data, instr_ready, acc_nz
    );

    modport slave (
        input  im_read, im_address, instr_out, operand_out, instr_valid,
        output im_data, instr_ready, acc_nz
    );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads one- or two-word instructions from instruction
// memory, presents them to the core with a valid/ready handshake, and follows JPNZ.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned      ADDR_MAX = 255,
    parameter logic [OPC_W-1:0] OP_LOAD  = OPC_LOAD,
    parameter logic [OPC_W-1:0] OP_JPNZ  = OPC_JPNZ,
    parameter logic [OPC_W-1:0] OP_END   = OPC_END
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    instr_fetch_unit_if.master  bus,
    output logic                busy,
    output logic                halted,
    output logic                fault,
    output logic [WORD_W-1:0]   retired
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic              im_read_q, im_read_d;
    logic [WORD_W-1:0] im_address_q, im_address_d;
    instr_t            instr_out_q, instr_out_d;
    logic [WORD_W-1:0] operand_out_q, operand_out_d;
    logic              instr_valid_q, instr_valid_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;
    logic [WORD_W-1:0] retired_q, retired_d;

    logic              launch;
    logic              handshake;
    logic              fetch_go;
    fetch_state_e      fetch_state;
    logic [WORD_W-1:0] fetch_addr;
    logic [OPC_W-1:0]  opcode;

    assign opcode    = instr_out_q.opcode;
    assign launch    = start && ((state_q == IDLE) || (state_q == HALT));
    assign handshake = (state_q == ISSUE) && instr_valid_q && bus.instr_ready;

    // Program counter: cleared on start, advanced or redirected on each handshake.
    always_comb begin : next_pc
        pc_d = pc_q;
        if (launch) begin
            pc_d = '0;
        end else if (handshake) begin
            if (opcode == OP_JPNZ) begin
                pc_d = bus.acc_nz ? operand_out_q : WORD_W'(pc_q + 16'd2);
            end else if (opcode == OP_LOAD) begin
                pc_d = WORD_W'(pc_q + 16'd2);
            end else begin
                pc_d = WORD_W'(pc_q + 16'd1);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin : next_state
        state_d       = state_q;
        im_read_d     = 1'b0;
        im_address_d  = im_address_q;
        instr_out_d   = instr_out_q;
        operand_out_d = operand_out_q;
        instr_valid_d = 1'b0;
        busy_d        = busy_q;
        halted_d      = halted_q;
        fault_d       = fault_q;
        retired_d     = retired_q;
        fetch_go      = 1'b0;
        fetch_state   = FETCH1;
        fetch_addr    = pc_q;

        unique case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    retired_d  = '0;
                    fault_d    = 1'b0;
                    halted_d   = 1'b0;
                    busy_d     = 1'b1;
                    fetch_go   = 1'b1;
                    fetch_addr = pc_d;
                end
            end
            FETCH1: state_d = LATCH1;
            LATCH1: begin
                instr_out_d = instr_t'(bus.im_data);
                if ((bus.im_data[OPC_W-1:0] == OP_LOAD) || (bus.im_data[OPC_W-1:0] == OP_JPNZ)) begin
                    fetch_go    = 1'b1;
                    fetch_state = FETCH2;
                    fetch_addr  = WORD_W'(pc_q + 16'd1);
                end else begin
                    operand_out_d = '0;
                    instr_valid_d = 1'b1;
                    state_d       = ISSUE;
                end
            end
            FETCH2: state_d = LATCH2;
            LATCH2: begin
                operand_out_d = bus.im_data;
                instr_valid_d = 1'b1;
                state_d       = ISSUE;
            end
            ISSUE: begin
                instr_valid_d = 1'b1;
                if (handshake) begin
                    instr_valid_d = 1'b0;
                    retired_d     = WORD_W'(retired_q + 16'd1);
                    if (opcode == OP_END) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                        busy_d   = 1'b0;
                    end else begin
                        fetch_go   = 1'b1;
                        fetch_addr = pc_d;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Any fetch beyond the legal window halts with a fault instead of reading.
        if (fetch_go) begin
            if (32'(fetch_addr) > ADDR_MAX) begin
                state_d  = HALT;
                fault_d  = 1'b1;
                halted_d = 1'b1;
                busy_d   = 1'b0;
            end else begin
                state_d      = fetch_state;
                im_read_d    = 1'b1;
                im_address_d = fetch_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            im_read_q     <= 1'b0;
            im_address_q  <= '0;
            instr_out_q   <= '0;
            operand_out_q <= '0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            retired_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            im_read_q     <= im_read_d;
            im_address_q  <= im_address_d;
            instr_out_q   <= instr_out_d;
            operand_out_q <= operand_out_d;
            instr_valid_q <= instr_valid_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
            retired_q     <= retired_d;
        end
    end

    assign bus.im_read     = im_read_q;
    assign bus.im_address  = im_address_q;
    assign bus.instr_out   = instr_out_q;
    assign bus.operand_out = operand_out_q;
    assign bus.instr_valid = instr_valid_q;
    assign busy            = busy_q;
    assign halted          = halted_q;
    assign fault           = fault_q;
    assign retired         = retired_q;

endmodule
